// File: rtl/reset_mon_pkg.sv
// Shared definitions for the lock-loss monitor: FSM state encodings,
// LOSS_SRC bit positions and the loss-counter width.
package reset_mon_pkg;

  localparam int CNT_W    = 8;
  localparam int N_SRC    = 3;
  localparam int SRC_DAQ  = 0;
  localparam int SRC_TRG  = 1;
  localparam int SRC_QPLL = 2;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_QUAL     = 3'd2,
    ST_RESTART  = 3'd3,
    ST_HOLDOFF  = 3'd4
  } mon_state_e;

  // Saturating increment used by the per-source loss counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer; both flops reset to 0 so an input reads
// as "unlocked" until it has been sampled twice after reset release.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/lock_loss_monitor.sv
// Qualifies persistent MMCM/QPLL lock loss into a stretched restart request.
// Define QPLL_MON_EN to include QPLL_LOCK in qualification and counting.
module lock_loss_monitor
  import reset_mon_pkg::*;
#(
  parameter logic [7:0]  DEB_CNT = 8'd100,
  parameter logic [3:0]  RST_PW  = 4'd15,
  parameter logic [15:0] HOLDOFF = 16'hFFFF
) (
  input  logic             CLK,
  input  logic             EOS,
  input  logic             RUN,
  input  logic             DAQ_MMCM_LOCK,
  input  logic             TRG_MMCM_LOCK,
  input  logic             QPLL_LOCK,
  input  logic             CNT_CLR,
  output logic             RESTART_REQ,
  output logic [2:0]       LOSS_SRC,
  output logic [CNT_W-1:0] DAQ_LOSS_CNT,
  output logic [CNT_W-1:0] TRG_LOSS_CNT,
  output logic [CNT_W-1:0] QPLL_LOSS_CNT,
  output logic [2:0]       MON_STATE
);

  logic [N_SRC-1:0] w_lock_sync;
  logic [N_SRC-1:0] w_mask;
  logic [N_SRC-1:0] w_lost;

  mon_state_e       r_state;
  mon_state_e       w_state_nxt;
  logic [7:0]       r_deb_cnt;
  logic [3:0]       r_pw_cnt;
  logic [15:0]      r_ho_cnt;
  logic             r_restart_req;
  logic [N_SRC-1:0] r_loss_src;
  logic [CNT_W-1:0] r_daq_cnt;
  logic [CNT_W-1:0] r_trg_cnt;
  logic             w_qualify;
  logic             w_deb_inc;

  sync2 u_sync_daq (
    .i_clk   (CLK),
    .i_rst_n (EOS),
    .i_d     (DAQ_MMCM_LOCK),
    .o_q     (w_lock_sync[SRC_DAQ])
  );

  sync2 u_sync_trg (
    .i_clk   (CLK),
    .i_rst_n (EOS),
    .i_d     (TRG_MMCM_LOCK),
    .o_q     (w_lock_sync[SRC_TRG])
  );

`ifdef QPLL_MON_EN
  logic [CNT_W-1:0] r_qpll_cnt;

  sync2 u_sync_qpll (
    .i_clk   (CLK),
    .i_rst_n (EOS),
    .i_d     (QPLL_LOCK),
    .o_q     (w_lock_sync[SRC_QPLL])
  );

  assign w_mask = 3'b111;

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      r_qpll_cnt <= '0;
    end else if (CNT_CLR) begin
      r_qpll_cnt <= '0;
    end else if (w_qualify && w_lost[SRC_QPLL]) begin
      r_qpll_cnt <= sat_inc(r_qpll_cnt);
    end
  end

  assign QPLL_LOSS_CNT = r_qpll_cnt;
`else
  // QPLL is not monitored in this build; its lock input is deliberately dropped.
  logic w_unused_qpll;
  assign w_unused_qpll            = QPLL_LOCK;
  assign w_lock_sync[SRC_QPLL]    = 1'b1;
  assign w_mask                   = 3'b011;
  assign QPLL_LOSS_CNT            = '0;
`endif

  assign w_lost = ~w_lock_sync & w_mask;

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      r_state <= ST_DISARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RESTART ignores RUN so a started pulse always reaches the reset manager in full.
  always_comb begin
    w_state_nxt = r_state;
    w_qualify   = 1'b0;
    w_deb_inc   = 1'b0;
    case (r_state)
      ST_DISARMED: begin
        if (RUN && !(|w_lost)) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (!RUN)           w_state_nxt = ST_DISARMED;
        else if (|w_lost)   w_state_nxt = ST_QUAL;
      end
      ST_QUAL: begin
        if (!RUN) begin
          w_state_nxt = ST_DISARMED;
        end else if (!(|w_lost)) begin
          w_state_nxt = ST_ARMED;
        end else if (r_deb_cnt == DEB_CNT - 8'd1) begin
          w_state_nxt = ST_RESTART;
          w_qualify   = 1'b1;
        end else begin
          w_deb_inc   = 1'b1;
        end
      end
      ST_RESTART: begin
        if (r_pw_cnt == RST_PW - 4'd1) w_state_nxt = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (!RUN)                                           w_state_nxt = ST_DISARMED;
        else if ((17'(r_ho_cnt) + 17'd1) >= 17'(HOLDOFF))   w_state_nxt = ST_DISARMED;
      end
      default: w_state_nxt = ST_DISARMED;
    endcase
  end

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      r_deb_cnt     <= '0;
      r_pw_cnt      <= '0;
      r_ho_cnt      <= '0;
      r_restart_req <= 1'b0;
      r_loss_src    <= '0;
    end else begin
      r_deb_cnt     <= w_deb_inc ? r_deb_cnt + 8'd1 : 8'd0;
      r_pw_cnt      <= (r_state == ST_RESTART) ? r_pw_cnt + 4'd1 : 4'd0;
      r_ho_cnt      <= (r_state == ST_HOLDOFF) ? r_ho_cnt + 16'd1 : 16'd0;
      r_restart_req <= (w_state_nxt == ST_RESTART);
      if (w_qualify) r_loss_src <= w_lost;
    end
  end

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      r_daq_cnt <= '0;
      r_trg_cnt <= '0;
    end else if (CNT_CLR) begin
      r_daq_cnt <= '0;
      r_trg_cnt <= '0;
    end else if (w_qualify) begin
      if (w_lost[SRC_DAQ]) r_daq_cnt <= sat_inc(r_daq_cnt);
      if (w_lost[SRC_TRG]) r_trg_cnt <= sat_inc(r_trg_cnt);
    end
  end

  assign RESTART_REQ  = r_restart_req;
  assign LOSS_SRC     = r_loss_src;
  assign DAQ_LOSS_CNT = r_daq_cnt;
  assign TRG_LOSS_CNT = r_trg_cnt;
  assign MON_STATE    = r_state;

endmodule

// File: tb/tb_lock_loss_monitor.sv
// Bench for lock_loss_monitor (DEB_CNT=4, RST_PW=15, HOLDOFF=20); honours QPLL_MON_EN.
module tb_lock_loss_monitor;

  localparam int P_DEB = 4;
  localparam int P_PW  = 15;
  localparam int P_HO  = 20;
`ifdef QPLL_MON_EN
  localparam logic [2:0] MASK = 3'b111;
`else
  localparam logic [2:0] MASK = 3'b011;
`endif

  logic       CLK = 1'b0;
  logic       EOS, RUN, DAQ_MMCM_LOCK, TRG_MMCM_LOCK, QPLL_LOCK, CNT_CLR;
  logic       RESTART_REQ;
  logic [2:0] LOSS_SRC, MON_STATE;
  logic [7:0] DAQ_LOSS_CNT, TRG_LOSS_CNT, QPLL_LOSS_CNT;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  lock_loss_monitor #(.DEB_CNT(8'd4), .RST_PW(4'd15), .HOLDOFF(16'd20)) dut (
    .CLK           (CLK),
    .EOS           (EOS),
    .RUN           (RUN),
    .DAQ_MMCM_LOCK (DAQ_MMCM_LOCK),
    .TRG_MMCM_LOCK (TRG_MMCM_LOCK),
    .QPLL_LOCK     (QPLL_LOCK),
    .CNT_CLR       (CNT_CLR),
    .RESTART_REQ   (RESTART_REQ),
    .LOSS_SRC      (LOSS_SRC),
    .DAQ_LOSS_CNT  (DAQ_LOSS_CNT),
    .TRG_LOSS_CNT  (TRG_LOSS_CNT),
    .QPLL_LOSS_CNT (QPLL_LOSS_CNT),
    .MON_STATE     (MON_STATE)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: restart on DEB_CNT+1 consecutive lost samples while watching.
  int         m_phase;  // 0 idle, 1 watching, 2 pulsing, 3 holding off
  int         m_run;
  int         m_left;
  logic [2:0] m_src;
  int         m_cnt [3];
  logic [2:0] m_hist[$];

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_left = 0; m_src = 3'b000;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_hist.delete();
    m_hist.push_back(3'b000);
    m_hist.push_back(3'b000);
  endtask

  function automatic int m_state_code();
    case (m_phase)
      0:       return 0;
      1:       return (m_run > 0) ? 2 : 1;
      2:       return 3;
      default: return 4;
    endcase
  endfunction

  task automatic model_step();
    logic [2:0] lost;
    logic       qual;
    lost = ~m_hist[0] & MASK;
    qual = 1'b0;
    case (m_phase)
      0: if (RUN && lost == 3'b000) begin m_phase = 1; m_run = 0; end
      1: begin
        if (!RUN) begin
          m_phase = 0; m_run = 0;
        end else if (lost != 3'b000) begin
          m_run++;
          if (m_run == P_DEB + 1) begin qual = 1'b1; m_phase = 2; m_left = P_PW; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) begin m_phase = 3; m_left = P_HO; end
      end
      default: begin
        if (!RUN) m_phase = 0;
        else begin
          m_left--;
          if (m_left == 0) m_phase = 0;
        end
      end
    endcase
    if (CNT_CLR) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else if (qual) begin
      for (int i = 0; i < 3; i++) if (lost[i] && m_cnt[i] < 255) m_cnt[i]++;
    end
    if (qual) m_src = lost;
    void'(m_hist.pop_front());
    m_hist.push_back({QPLL_LOCK, TRG_MMCM_LOCK, DAQ_MMCM_LOCK});
  endtask

  task automatic compare_model();
    check("model_req", RESTART_REQ, int'(m_phase == 2));
    check("model_loss_src", LOSS_SRC, m_src);
    check("model_daq_cnt", DAQ_LOSS_CNT, m_cnt[0]);
    check("model_trg_cnt", TRG_LOSS_CNT, m_cnt[1]);
    check("model_qpll_cnt", QPLL_LOSS_CNT, m_cnt[2]);
    check("model_state", MON_STATE, m_state_code());
  endtask

  // One clock: inputs already driven; outputs sampled on the falling edge.
  task automatic step();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    compare_model();
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
    int k = 0;
    while (MON_STATE != tgt && k < budget) begin
      step();
      k++;
    end
    check(name, MON_STATE, tgt);
  endtask

  task automatic episode(input logic [2:0] drop, input int low,
                         output logic saw, output logic [2:0] src);
    saw = 1'b0;
    src = 3'b000;
    {QPLL_LOCK, TRG_MMCM_LOCK, DAQ_MMCM_LOCK} = ~drop;
    for (int k = 0; k < low + 4; k++) begin
      if (k == low) {QPLL_LOCK, TRG_MMCM_LOCK, DAQ_MMCM_LOCK} = 3'b111;
      step();
      if (RESTART_REQ && !saw) begin saw = 1'b1; src = LOSS_SRC; end
    end
    wait_state(3'd1, 80, "episode_rearm");
  endtask

  typedef struct {
    logic [2:0] drop;
    int         low;
    logic       exp_req;
    logic [2:0] exp_src;
  } vec_t;

  vec_t       tbl [6];
  logic       saw;
  logic [2:0] src;
  logic [2:0] lk;
  int         len [3];
  int         width;
  int         run_off;

  initial begin
    tbl[0] = '{3'b001, 3, 1'b0, 3'b000};
    tbl[1] = '{3'b001, 4, 1'b0, 3'b000};
    tbl[2] = '{3'b001, 5, 1'b1, 3'b001};
    tbl[3] = '{3'b010, 5, 1'b1, 3'b010};
    tbl[4] = '{3'b011, 6, 1'b1, 3'b011};
    tbl[5] = '{3'b010, 1, 1'b0, 3'b000};

    EOS = 1'b0; RUN = 1'b0; CNT_CLR = 1'b0;
    DAQ_MMCM_LOCK = 1'b0; TRG_MMCM_LOCK = 1'b0; QPLL_LOCK = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    check("rst_req", RESTART_REQ, 0);
    check("rst_state", MON_STATE, 0);
    check("rst_src", LOSS_SRC, 0);
    check("rst_daq_cnt", DAQ_LOSS_CNT, 0);
    EOS = 1'b1;

    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (cyc == 10) {QPLL_LOCK, TRG_MMCM_LOCK, DAQ_MMCM_LOCK} = 3'b111;
      if (cyc == 20) RUN = 1'b1;
      step();
      if (cyc == 21) check("armed_by_21", MON_STATE, 1);
    end

    for (int i = 0; i < 6; i++) begin
      episode(tbl[i].drop, tbl[i].low, saw, src);
      check($sformatf("tbl%0d_req", i), saw, tbl[i].exp_req);
      if (tbl[i].exp_req) check($sformatf("tbl%0d_src", i), src, tbl[i].exp_src);
      if (i == 0) check("short_loss_daq_cnt", DAQ_LOSS_CNT, 0);
    end
    check("tbl_daq_cnt", DAQ_LOSS_CNT, 2);
    check("tbl_trg_cnt", TRG_LOSS_CNT, 2);

    TRG_MMCM_LOCK = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) check("trg_req_low_edge6", RESTART_REQ, 0);
    end
    check("trg_req_edge7", RESTART_REQ, 1);
    check("trg_state_restart", MON_STATE, 3);
    check("trg_src", LOSS_SRC, 3'b010);
    check("trg_cnt", TRG_LOSS_CNT, 3);
    width = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (RESTART_REQ) width++;
    end
    check("trg_pulse_width", width, 15);
    TRG_MMCM_LOCK = 1'b1;
    wait_state(3'd1, 80, "trg_rearm");

    episode(3'b101, 7, saw, src);
    check("dq_req", saw, 1);
    check("dq_daq_cnt", DAQ_LOSS_CNT, 3);
`ifdef QPLL_MON_EN
    check("dq_src", src, 3'b101);
    check("dq_qpll_cnt", QPLL_LOSS_CNT, 1);
`else
    check("dq_src", src, 3'b001);
    check("dq_qpll_cnt", QPLL_LOSS_CNT, 0);
`endif

    lk = 3'b111;
    for (int b = 0; b < 3; b++) len[b] = 0;
    run_off = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (len[b] > 0) begin
          len[b]--;
          if (len[b] == 0) lk[b] = 1'b1;
        end else if ($urandom_range(0, 39) == 0) begin
          len[b] = $urandom_range(1, 9);
          lk[b]  = 1'b0;
        end
      end
      {QPLL_LOCK, TRG_MMCM_LOCK, DAQ_MMCM_LOCK} = lk;
      if (run_off > 0) run_off--;
      else if ($urandom_range(0, 299) == 0) run_off = $urandom_range(1, 5);
      RUN     = (run_off == 0);
      CNT_CLR = ($urandom_range(0, 199) == 0);
      step();
    end
    {QPLL_LOCK, TRG_MMCM_LOCK, DAQ_MMCM_LOCK} = 3'b111;
    RUN = 1'b1;
    CNT_CLR = 1'b0;
    wait_state(3'd1, 200, "rand_rearm");

    CNT_CLR = 1'b1;
    step();
    CNT_CLR = 1'b0;
    check("clr_daq_cnt", DAQ_LOSS_CNT, 0);
    for (int n = 1; n <= 300; n++) begin
      DAQ_MMCM_LOCK = 1'b0;
      for (int k = 0; k < 6; k++) step();
      if (n == 300) begin
        check("sat_before_clr", DAQ_LOSS_CNT, 255);
        check("req_before_qual", RESTART_REQ, 0);
        CNT_CLR = 1'b1;
      end
      step();
      CNT_CLR = 1'b0;
      if (n == 255 || n == 256) check($sformatf("sat_at_%0d", n), DAQ_LOSS_CNT, 255);
      if (n == 300) begin
        check("clr_wins", DAQ_LOSS_CNT, 0);
        check("req_on_clr_edge", RESTART_REQ, 1);
      end
      DAQ_MMCM_LOCK = 1'b1;
      wait_state(3'd1, 80, "loss_rearm");
    end

    TRG_MMCM_LOCK = 1'b0;
    wait_state(3'd4, 60, "reach_holdoff");
    TRG_MMCM_LOCK = 1'b1;
    step();
    step();
    RUN = 1'b0;
    step();
    check("run_drop_holdoff", MON_STATE, 0);
    RUN = 1'b1;
    wait_state(3'd1, 20, "rerun_arm");

    TRG_MMCM_LOCK = 1'b0;
    wait_state(3'd3, 20, "reach_restart");
    repeat (4) step();
    check("req_before_eos", RESTART_REQ, 1);
    #2;
    EOS = 1'b0;
    #1;
    check("eos_req_async", RESTART_REQ, 0);
    check("eos_state", MON_STATE, 0);
    check("eos_src", LOSS_SRC, 0);
    check("eos_daq_cnt", DAQ_LOSS_CNT, 0);
    check("eos_trg_cnt", TRG_LOSS_CNT, 0);
    check("eos_qpll_cnt", QPLL_LOSS_CNT, 0);
    model_reset();
    @(negedge CLK);
    TRG_MMCM_LOCK = 1'b1;
    EOS = 1'b1;
    wait_state(3'd1, 20, "post_eos_arm");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lock_loss_monitor.md
# lock_loss_monitor

Watches the DAQ MMCM, trigger MMCM and QPLL lock indicators once the board is running. When a lock loss persists, it issues a qualified, stretched restart request into the power-on reset manager's restart input, which it shares with the JTAG/CSP system resets. It keeps saturating per-source loss counters for slow-control readback. It sits directly upstream of the reset manager, in the startup clock domain.

## Interface
Parameters:
- DEB_CNT, 8'd100 — consecutive cycles a loss must persist before a restart is requested (legal 1..255).
- RST_PW, 4'd15 — RESTART_REQ pulse width in cycles (legal 1..15).
- HOLDOFF, 16'hFFFF — cycles ignored after a restart before re-arming is allowed.

Ports:
- CLK  input  1  startup clock; all logic on posedge.
- EOS  input  1  asynchronous, active-low reset (negedge asserts).
- RUN  input  1  reset-manager RUN status; arms the monitor.
- DAQ_MMCM_LOCK  input  1  asynchronous lock indicator.
- TRG_MMCM_LOCK  input  1  asynchronous lock indicator.
- QPLL_LOCK  input  1  asynchronous lock indicator.
- CNT_CLR  input  1  synchronous clear of all loss counters.
- RESTART_REQ  output  1  restart request to the reset manager; registered.
- LOSS_SRC  output  3  sources lost at qualification; bit0 DAQ, bit1 TRG, bit2 QPLL.
- DAQ_LOSS_CNT  output  8  saturating loss count.
- TRG_LOSS_CNT  output  8  saturating loss count.
- QPLL_LOSS_CNT  output  8  saturating loss count.
- MON_STATE  output  3  current FSM state encoding.

## Operation
- Each lock input passes through a 2-flop synchronizer. lost[i] = ~lock_sync[i] & mask[i].
- States and encodings:
  - DISARMED (0): go to ARMED when RUN=1 and lost==0.
  - ARMED (1): go to QUAL when lost!=0. Clear deb_cnt.
  - QUAL (2): each cycle with lost!=0, increment deb_cnt.
    - If lost==0, return to ARMED.
    - When deb_cnt==DEB_CNT-1 and lost!=0, go to RESTART. Latch LOSS_SRC=lost and increment the counter of each set bit.
  - RESTART (3): RESTART_REQ=1 for exactly RST_PW cycles, then go to HOLDOFF.
  - HOLDOFF (4): count HOLDOFF cycles, then go to DISARMED.
- RUN=0 in ARMED, QUAL or HOLDOFF forces DISARMED on the next edge. RESTART always completes its full pulse.
- Counters saturate at 8'hFF.
- CNT_CLR clears all three counters. If CNT_CLR coincides with an increment, the clear wins.
- LOSS_SRC holds its value until the next qualification.
- Reset (EOS=0): state DISARMED; RESTART_REQ=0; LOSS_SRC=0; all counters=0; deb_cnt=0; holdoff counter=0; synchronizer flops=0 (unlocked).
- An EOS assertion mid-pulse drops RESTART_REQ immediately (asynchronous).

## Timing
- RESTART_REQ rises DEB_CNT+3 CLK edges after the first edge that samples a low lock input.
  - 2 edges of synchronization, 1 edge to enter QUAL, DEB_CNT edges of qualification.
- Loss shorter than DEB_CNT cycles, as seen at the synchronizer output, never produces a request.
- Counters and LOSS_SRC update on the same edge that RESTART_REQ rises.
- Re-arm occurs no earlier than RST_PW+HOLDOFF+1 edges after RESTART_REQ rises.
- MON_STATE is the registered state; no combinational path exists from inputs to outputs.

## Configuration
- QPLL_MON_EN defined: mask[2]=1, so QPLL loss qualifies restarts and increments QPLL_LOSS_CNT.
- QPLL_MON_EN undefined: mask[2]=0, so QPLL_LOCK is ignored, QPLL_LOSS_CNT is tied to 8'h00 and LOSS_SRC[2]=0. The QPLL synchronizer is removed.

## Structure
- Package reset_mon_pkg holds:
  - state encodings DISARMED..HOLDOFF;
  - LOSS_SRC bit indices SRC_DAQ=0, SRC_TRG=1, SRC_QPLL=2;
  - counter width CNT_W=8.
- Sub-module sync2: a generic 2-flop synchronizer with async active-low reset value 0, instantiated once per lock input.

## Test plan
- Reset release; all locks high at cycle 10; RUN=1 at cycle 20 → MON_STATE=1 by cycle 21; RESTART_REQ=0; counters=0.
- ARMED, DEB_CNT=4; DAQ_MMCM_LOCK low for 3 cycles (after synchronization) then high → no RESTART_REQ; state returns to ARMED; DAQ_LOSS_CNT=0.
- ARMED, DEB_CNT=4, RST_PW=15; TRG_MMCM_LOCK held low → RESTART_REQ high exactly 7 edges after the first low sample, for 15 cycles; LOSS_SRC=3'b010; TRG_LOSS_CNT=1.
- DAQ and QPLL drop on the same cycle, run with and without QPLL_MON_EN → LOSS_SRC=3'b101 with DAQ and QPLL counts +1, versus LOSS_SRC=3'b001 and QPLL_LOSS_CNT=0.
- Force 300 qualified DAQ losses, asserting CNT_CLR on the edge of the 300th increment → counter held at 8'hFF before that edge, 8'h00 after it.
- Drop EOS mid-RESTART (pulse cycle 5) → RESTART_REQ=0 asynchronously; state DISARMED; counters 0. Drop RUN in HOLDOFF → DISARMED on the next edge.
